pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Pipelined successor to the single-cycle control decoder.
- Decodes the ID-stage instruction into a control bundle and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use and RAW hazards, generates forwarding selects, and produces PC/IF-ID write enables, flushes and the next-PC operation.
- Sits beside the 5-stage datapath. The datapath owns the data registers; this block owns every control register.

Parameters:
- AW, 5: register address width. Link register index is 2^AW-1.
- ALUOP_W, 4: ALUOp width. Encodings per ctrl_encode_def.v, zero-extended.
- FWD_EN, 1: 1 = forwarding with load-use stall only; 0 = no forwarding, stall on any RAW hazard.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID instruction is valid. When 0, ID decodes as a bubble.
- id_op  in  6  opcode.
- id_funct  in  6  funct.
- id_rs, id_rt, id_rd  in  AW  source/destination fields.
- ex_zero  in  1  ALU Zero from EX stage.
- ex_alu_op  out  ALUOP_W  ID/EX ALUOp.
- ex_alu_src  out  1  ID/EX ALUSrc.
- ex_areg_sel  out  1  ID/EX shift-amount select.
- ex_ext_op  out  1  ID/EX sign-extend.
- ex_rs, ex_rt  out  AW  ID/EX source indices.
- mem_mem_write  out  1  EX/MEM MemWrite.
- mem_mem_read  out  1  EX/MEM MemRead.
- wb_reg_write  out  1  MEM/WB RegWrite.
- wb_wd_sel  out  2  MEM/WB WDSel.
- wb_wr_addr  out  AW  MEM/WB destination.
- fwd_a, fwd_b  out  2  00 = register file, 01 = MEM/WB, 10 = EX/MEM.
- pc_write  out  1  PC enable.
- ifid_write  out  1  IF/ID enable.
- flush_if  out  1  IF/ID load bubble.
- npc_op  out  2  00 = +4, 01 = branch, 10 = jump, 11 = jump-register.

Behaviour:
- ID decode is combinational, using the same instruction subset and encodings as the single-cycle unit.
- ID decode adds MemRead (lw) and is_branch/is_jr flags.
- Destination select: wr_addr = rd for R-type, rt for I-type, 2^AW-1 for jal/jalr. uses_rs and uses_rt are decoded per opcode.
- Control register contents:
  - ID/EX: full bundle plus wr_addr, rs, rt, branch type.
  - EX/MEM: RegWrite, MemWrite, MemRead, WDSel, wr_addr.
  - MEM/WB: RegWrite, WDSel, wr_addr.
- All three control registers advance every cycle; there is no back-pressure beyond the stall rules below.
- Reset: all control registers clear to 0, so every registered output is 0. The combinational outputs are then pc_write=1, ifid_write=1, flush_if=0, npc_op=00, fwd=00.
- Reset mid-operation discards all in-flight control.
- Load-use stall (both FWD_EN settings): ID/EX MemRead=1, ID/EX wr_addr!=0, and the address matches rs (with uses_rs) or rt (with uses_rt).
- When stall=1:
  - pc_write=0, ifid_write=0.
  - ID/EX loads an all-zero bubble.
  - EX/MEM and MEM/WB advance normally.
- FWD_EN=0 adds a stall when an ID source matches a nonzero wr_addr with RegWrite=1 in ID/EX or EX/MEM. In this mode fwd_a=fwd_b=00.
- The register file writes before it reads, so a MEM/WB source match never stalls.
- Forwarding (FWD_EN=1), fwd_a:
  - 10 when EX/MEM RegWrite=1, wr_addr!=0 and wr_addr==ex_rs.
  - Otherwise 01 when the same conditions hold for MEM/WB.
  - Otherwise 00.
- fwd_b uses the same rules with ex_rt. EX/MEM wins when both stages match.
- EX redirect: a taken branch (beq & ex_zero, or bne & ~ex_zero), or jr/jalr in ID/EX. Effects:
  - npc_op = 01 for a taken branch, 11 for jr/jalr.
  - flush_if=1.
  - ID/EX loads a bubble on the next edge.
  - pc_write=1.
- ID jump (j/jal with id_valid): npc_op=10 and flush_if=1.
- Priority: EX redirect > load-use/RAW stall > ID jump > +4.
- A stall coincident with an EX redirect is ignored: the redirect flushes the stalled instruction anyway.
- An ID jump coincident with a stall waits; npc_op=00 and pc_write=0 until the stall clears.
- Writes to register 0 never create a hazard or a forward.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with a random ID instruction. Required: all registered outputs 0, pc_write=1, ifid_write=1, npc_op=00.
2. lw $8 followed by add $9,$8,$10. Required: one cycle with pc_write=0 and ifid_write=0, an ID/EX bubble (ex_alu_op=0), then fwd_a=01 when add reaches EX.
3. add $8,$1,$2 followed by sub $3,$8,$8 (FWD_EN=1). Required: no stall, fwd_a=fwd_b=10. With FWD_EN=0: 2 stall cycles, fwd=00.
4. beq with ex_zero=1. Required: npc_op=01 and flush_if=1 in that cycle, ID/EX bubble next cycle. With ex_zero=0: npc_op=00, no flush.
5. jal in ID. Required: npc_op=10, flush_if=1. Three cycles later: wb_wr_addr=31, wb_reg_write=1, wb_wd_sel=10.
6. add $0,$1,$2 followed by or $3,$0,$0. Required: fwd_a=fwd_b=00, no stall.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipelined control unit -- ID decode, ID/EX, EX/MEM and MEM/WB control registers,
// load-use/RAW hazard detection, forwarding selects and next-PC control.
module pipe_ctrl #(
  parameter int AW = 5,
  parameter int ALUOP_W = 4,
  parameter int FWD_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [5:0]         id_op,
  input  logic [5:0]         id_funct,
  input  logic [AW-1:0]      id_rs,
  input  logic [AW-1:0]      id_rt,
  input  logic [AW-1:0]      id_rd,
  input  logic               ex_zero,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alu_src,
  output logic               ex_areg_sel,
  output logic               ex_ext_op,
  output logic [AW-1:0]      ex_rs,
  output logic [AW-1:0]      ex_rt,
  output logic               mem_mem_write,
  output logic               mem_mem_read,
  output logic               wb_reg_write,
  output logic [1:0]         wb_wd_sel,
  output logic [AW-1:0]      wb_wr_addr,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               pc_write,
  output logic               ifid_write,
  output logic               flush_if,
  output logic [1:0]         npc_op
);
  localparam logic [AW-1:0] LINK = '1;
  localparam logic [ALUOP_W-1:0] A_ADD = ALUOP_W'(1), A_SUB = ALUOP_W'(2), A_AND = ALUOP_W'(3),
    A_OR = ALUOP_W'(4), A_SLT = ALUOP_W'(5), A_SLTU = ALUOP_W'(6), A_ADDU = ALUOP_W'(7),
    A_SUBU = ALUOP_W'(8), A_XOR = ALUOP_W'(9), A_NOR = ALUOP_W'(10), A_SLL = ALUOP_W'(11),
    A_SRL = ALUOP_W'(12), A_SRA = ALUOP_W'(13), A_LUI = ALUOP_W'(14);
  typedef struct packed {
    logic rw, mw, mr, asrc, asel, ext;
    logic [1:0] wd;
    logic [ALUOP_W-1:0] alu;
    logic beq, bne, jr;
    logic [AW-1:0] wr, rs, rt;
  } idex_t;
  typedef struct packed {
    logic rw, mw, mr;
    logic [1:0] wd;
    logic [AW-1:0] wr;
  } exmem_t;
  typedef struct packed {
    logic rw;
    logic [1:0] wd;
    logic [AW-1:0] wr;
  } memwb_t;
  idex_t  dec, idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;
  logic jmp, urs, urt, taken, redir, haz, stall;
  function automatic logic reads(input logic [AW-1:0] w, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                 input logic ur, input logic ut);
    return w != '0 && ((ur && rs == w) || (ut && rt == w));
  endfunction
  function automatic logic [1:0] fsel(input logic [AW-1:0] src, input exmem_t em, input memwb_t mw);
    return (em.rw && em.wr != '0 && em.wr == src) ? 2'b10 :
           (mw.rw && mw.wr != '0 && mw.wr == src) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    dec = '0;
    jmp = 1'b0;
    urs = 1'b0;
    urt = 1'b0;
    case (id_op)
      6'h00: begin
        dec.rw = 1'b1;
        urs = 1'b1;
        urt = 1'b1;
        case (id_funct)
          6'h20: dec.alu = A_ADD;
          6'h21: dec.alu = A_ADDU;
          6'h22: dec.alu = A_SUB;
          6'h23: dec.alu = A_SUBU;
          6'h24: dec.alu = A_AND;
          6'h25: dec.alu = A_OR;
          6'h26: dec.alu = A_XOR;
          6'h27: dec.alu = A_NOR;
          6'h2a: dec.alu = A_SLT;
          6'h2b: dec.alu = A_SLTU;
          6'h00: begin dec.alu = A_SLL; dec.asel = 1'b1; urs = 1'b0; end
          6'h02: begin dec.alu = A_SRL; dec.asel = 1'b1; urs = 1'b0; end
          6'h03: begin dec.alu = A_SRA; dec.asel = 1'b1; urs = 1'b0; end
          6'h08: begin dec.rw = 1'b0; dec.jr = 1'b1; urt = 1'b0; end
          6'h09: begin dec.wd = 2'b10; dec.jr = 1'b1; urt = 1'b0; end
          default: begin dec.rw = 1'b0; urs = 1'b0; urt = 1'b0; end
        endcase
      end
      6'h08: begin dec.rw = 1'b1; dec.asrc = 1'b1; dec.ext = 1'b1; dec.alu = A_ADD; urs = 1'b1; end
      6'h09: begin dec.rw = 1'b1; dec.asrc = 1'b1; dec.ext = 1'b1; dec.alu = A_ADDU; urs = 1'b1; end
      6'h0a: begin dec.rw = 1'b1; dec.asrc = 1'b1; dec.ext = 1'b1; dec.alu = A_SLT; urs = 1'b1; end
      6'h0c: begin dec.rw = 1'b1; dec.asrc = 1'b1; dec.alu = A_AND; urs = 1'b1; end
      6'h0d: begin dec.rw = 1'b1; dec.asrc = 1'b1; dec.alu = A_OR; urs = 1'b1; end
      6'h0e: begin dec.rw = 1'b1; dec.asrc = 1'b1; dec.alu = A_XOR; urs = 1'b1; end
      6'h0f: begin dec.rw = 1'b1; dec.asrc = 1'b1; dec.alu = A_LUI; end
      6'h23: begin
        dec.rw = 1'b1; dec.mr = 1'b1; dec.asrc = 1'b1; dec.ext = 1'b1; dec.wd = 2'b01;
        dec.alu = A_ADD; urs = 1'b1;
      end
      6'h2b: begin dec.mw = 1'b1; dec.asrc = 1'b1; dec.ext = 1'b1; dec.alu = A_ADD; urs = 1'b1; urt = 1'b1; end
      6'h04: begin dec.beq = 1'b1; dec.ext = 1'b1; dec.alu = A_SUB; urs = 1'b1; urt = 1'b1; end
      6'h05: begin dec.bne = 1'b1; dec.ext = 1'b1; dec.alu = A_SUB; urs = 1'b1; urt = 1'b1; end
      6'h02: jmp = 1'b1;
      6'h03: begin jmp = 1'b1; dec.rw = 1'b1; dec.wd = 2'b10; end
      default: ;
    endcase
    dec.wr = id_op == 6'h00 ? ((dec.jr & dec.rw) ? LINK : id_rd) : (id_op == 6'h03 ? LINK : id_rt);
    dec.rs = id_rs;
    dec.rt = id_rt;
    if (!id_valid) begin
      dec = '0;
      jmp = 1'b0;
      urs = 1'b0;
      urt = 1'b0;
    end
  end
  // a redirect flushes the ID instruction anyway, so it overrides any stall
  always_comb begin
    taken = (idex_q.beq & ex_zero) | (idex_q.bne & ~ex_zero);
    redir = taken | idex_q.jr;
    haz = (idex_q.mr & reads(idex_q.wr, dec.rs, dec.rt, urs, urt)) |
          ((FWD_EN == 0) & ((idex_q.rw & reads(idex_q.wr, dec.rs, dec.rt, urs, urt)) |
                            (exmem_q.rw & reads(exmem_q.wr, dec.rs, dec.rt, urs, urt))));
    stall = haz & ~redir & ~rst;
    pc_write = ~stall;
    ifid_write = ~stall;
    flush_if = ~rst & (redir | (jmp & ~stall));
    npc_op = rst ? 2'b00 : taken ? 2'b01 : idex_q.jr ? 2'b11 : (jmp & ~stall) ? 2'b10 : 2'b00;
    fwd_a = FWD_EN != 0 ? fsel(idex_q.rs, exmem_q, memwb_q) : 2'b00;
    fwd_b = FWD_EN != 0 ? fsel(idex_q.rt, exmem_q, memwb_q) : 2'b00;
    idex_d = (stall | redir) ? '0 : dec;
    exmem_d = '{rw: idex_q.rw, mw: idex_q.mw, mr: idex_q.mr, wd: idex_q.wd, wr: idex_q.wr};
    memwb_d = '{rw: exmem_q.rw, wd: exmem_q.wd, wr: exmem_q.wr};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end
  assign ex_alu_op = idex_q.alu;
  assign ex_alu_src = idex_q.asrc;
  assign ex_areg_sel = idex_q.asel;
  assign ex_ext_op = idex_q.ext;
  assign ex_rs = idex_q.rs;
  assign ex_rt = idex_q.rt;
  assign mem_mem_write = exmem_q.mw;
  assign mem_mem_read = exmem_q.mr;
  assign wb_reg_write = memwb_q.rw;
  assign wb_wd_sel = memwb_q.wd;
  assign wb_wr_addr = memwb_q.wr;
endmodule
